// File: rtl/serial_frame_collector.sv
// Assembles 32-bit frames from a bit stream kept in lockstep with a 5-bit frame counter,
// queues good frames in a small FIFO and counts frames lost to dropouts, desync or overflow.
//
// state   | meaning
// ALIGN   | waiting for count == 0 to start a new frame
// COLLECT | shifting bits, checking counter/wrap consistency
module serial_frame_collector #(
  parameter int FIFO_DEPTH = 2,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        serial_in,
  input  logic        bit_en,
  input  logic [4:0]  count,
  input  logic        reached,
  output logic [31:0] data_out,
  output logic        data_valid,
  input  logic        data_ready,
  output logic        overflow,
  output logic [7:0]  frames_dropped
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {ALIGN, COLLECT} state_t;

  state_t      state;
  logic [31:0] shreg;
  logic        frame_ok;

  logic [31:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
  logic [AW:0]   level, level_next;

  logic        count_zero, boundary, desync;
  logic        push_req, full, pop, push, lost, drop;
  logic [31:0] first_bit, shifted;

  always_comb begin
    count_zero = (count == 5'd0);
    boundary   = (state == COLLECT) && reached && count_zero;
    desync     = (state == COLLECT) && (reached != count_zero);
    push_req   = boundary && frame_ok;
    full       = (level == (AW+1)'(FIFO_DEPTH));
    pop        = data_valid && data_ready;
    push       = push_req && (!full || pop);
    lost       = push_req && full && !pop;
    drop       = (boundary && !frame_ok) || desync || lost;
    level_next = level + (AW+1)'(push) - (AW+1)'(pop);
    rd_next    = rd_ptr + AW'(pop);
    first_bit  = MSB_FIRST ? {31'b0, serial_in} : {serial_in, 31'b0};
    shifted    = MSB_FIRST ? {shreg[30:0], serial_in} : {serial_in, shreg[31:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ALIGN;
      shreg          <= '0;
      frame_ok       <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      level          <= '0;
      data_out       <= '0;
      data_valid     <= 1'b0;
      overflow       <= 1'b0;
      frames_dropped <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        ALIGN: begin
          if (count_zero) begin
            shreg    <= first_bit;
            frame_ok <= bit_en;
            state    <= COLLECT;
          end
        end
        COLLECT: begin
          if (desync) begin
            shreg    <= '0;
            frame_ok <= 1'b0;
            state    <= ALIGN;
          end else if (boundary) begin
            shreg    <= first_bit;
            frame_ok <= bit_en;
          end else begin
            shreg    <= shifted;
            frame_ok <= frame_ok & bit_en;
          end
        end
        default: state <= ALIGN;
      endcase

      if (push) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      rd_ptr     <= rd_next;
      level      <= level_next;
      data_valid <= (level_next != '0);
      // Head word is registered; a word written this edge can itself become the head.
      if (push && (wr_ptr == rd_next)) data_out <= shreg;
      else                             data_out <= mem[rd_next];

      if (lost) overflow <= 1'b1;
      if (drop && (frames_dropped != 8'hFF)) frames_dropped <= frames_dropped + 8'd1;
    end
  end

endmodule

// File: tb/tb_serial_frame_collector.sv
// Directed bench for serial_frame_collector: a software frame counter drives count/reached,
// and each scenario checks delivered words, drop counts and the overflow flag.
module tb_serial_frame_collector;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        serial_in = 1'b0;
  logic        bit_en = 1'b0;
  logic [4:0]  count = '0;
  logic        reached = 1'b0;
  logic        data_ready = 1'b0;
  logic [31:0] data_out, data_out_lsb;
  logic        data_valid, data_valid_lsb;
  logic        overflow, overflow_lsb;
  logic [7:0]  frames_dropped, frames_dropped_lsb;

  int checks = 0;
  int errors = 0;
  logic [4:0] cnt_v = '0;
  logic       wrap_v = 1'b0;

  serial_frame_collector #(.FIFO_DEPTH(2), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .serial_in(serial_in), .bit_en(bit_en),
    .count(count), .reached(reached), .data_out(data_out), .data_valid(data_valid),
    .data_ready(data_ready), .overflow(overflow), .frames_dropped(frames_dropped)
  );

  serial_frame_collector #(.FIFO_DEPTH(2), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .serial_in(serial_in), .bit_en(bit_en),
    .count(count), .reached(reached), .data_out(data_out_lsb), .data_valid(data_valid_lsb),
    .data_ready(data_ready), .overflow(overflow_lsb), .frames_dropped(frames_dropped_lsb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rev(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // One clock: drive inputs from the software counter, then step past the edge.
  task automatic cyc(input logic sin, input logic en, input logic rdy, input logic frc);
    serial_in  = sin;
    bit_en     = en;
    data_ready = rdy;
    count      = cnt_v;
    reached    = wrap_v | frc;
    @(posedge clk);
    #1;
    cnt_v  = cnt_v + 5'd1;
    wrap_v = (cnt_v == 5'd0);
  endtask

  task automatic bits(input logic [31:0] w, input int from, input int to, input int drop,
                      input logic rdy);
    for (int i = from; i <= to; i++) cyc(w[31-i], (i != drop), rdy, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    reset  = 1'b0;
    cnt_v  = '0;
    wrap_v = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset state
    do_reset();
    check("rst_valid", data_valid, 0);
    check("rst_data", data_out, 0);
    check("rst_ovf", overflow, 0);
    check("rst_drop", frames_dropped, 0);

    // basic frame, both bit orders
    bits(32'hA5A5_0F0F, 0, 31, -1, 1'b1);
    check("bas_pre_valid", data_valid, 0);
    bits(32'h0F0F_A5A5, 0, 0, -1, 1'b1);
    check("bas_valid", data_valid, 1);
    check("bas_data", data_out, 32'hA5A5_0F0F);
    check("bas_lsb_valid", data_valid_lsb, 1);
    check("bas_lsb_data", data_out_lsb, rev(32'hA5A5_0F0F));
    bits(32'h0F0F_A5A5, 1, 1, -1, 1'b1);
    check("bas_one_cycle", data_valid, 0);
    bits(32'h0F0F_A5A5, 2, 31, -1, 1'b1);
    bits(32'h0, 0, 0, -1, 1'b1);
    check("bas2_valid", data_valid, 1);
    check("bas2_data", data_out, 32'h0F0F_A5A5);

    // bit dropout
    do_reset();
    bits(32'hDEAD_BEEF, 0, 31, 7, 1'b1);
    bits(32'h1234_5678, 0, 0, -1, 1'b1);
    check("drp_no_word", data_valid, 0);
    check("drp_count", frames_dropped, 1);
    bits(32'h1234_5678, 1, 31, -1, 1'b1);
    bits(32'h0, 0, 0, -1, 1'b1);
    check("drp_f2_valid", data_valid, 1);
    check("drp_f2_data", data_out, 32'h1234_5678);
    check("drp_count2", frames_dropped, 1);

    // overflow with depth 2
    do_reset();
    bits(32'h1, 0, 31, -1, 1'b0);
    bits(32'h2, 0, 31, -1, 1'b0);
    bits(32'h3, 0, 31, -1, 1'b0);
    bits(32'h4, 0, 0, -1, 1'b0);
    check("ovf_first", overflow, 1);
    check("ovf_drop1", frames_dropped, 1);
    check("ovf_head", data_out, 32'h1);
    bits(32'h4, 1, 31, -1, 1'b0);
    bits(32'h0, 0, 0, -1, 1'b0);
    check("ovf_flag", overflow, 1);
    check("ovf_drop2", frames_dropped, 2);
    check("ovf_valid", data_valid, 1);
    check("ovf_drain1", data_out, 32'h1);
    bits(32'h0, 1, 1, -1, 1'b1);
    check("ovf_drain2_valid", data_valid, 1);
    check("ovf_drain2", data_out, 32'h2);
    bits(32'h0, 2, 2, -1, 1'b1);
    check("ovf_empty", data_valid, 0);
    check("ovf_sticky", overflow, 1);

    // push with simultaneous pop on a full FIFO
    do_reset();
    bits(32'hCAFE_0001, 0, 31, -1, 1'b0);
    bits(32'hCAFE_0002, 0, 31, -1, 1'b0);
    bits(32'hCAFE_0003, 0, 0, -1, 1'b0);
    check("pp_head_a", data_out, 32'hCAFE_0001);
    bits(32'hCAFE_0003, 1, 31, -1, 1'b0);
    bits(32'hCAFE_0004, 0, 0, -1, 1'b1);
    check("pp_ovf", overflow, 0);
    check("pp_drop", frames_dropped, 0);
    check("pp_head_b", data_out, 32'hCAFE_0002);
    bits(32'hCAFE_0004, 1, 1, -1, 1'b1);
    check("pp_c_valid", data_valid, 1);
    check("pp_head_c", data_out, 32'hCAFE_0003);
    bits(32'hCAFE_0004, 2, 2, -1, 1'b1);
    check("pp_empty", data_valid, 0);

    // desync: reached with count = 5
    do_reset();
    bits(32'h0BAD_F00D, 0, 31, -1, 1'b1);
    bits(32'h5555_AAAA, 0, 0, -1, 1'b1);
    check("ds_prev_data", data_out, 32'h0BAD_F00D);
    bits(32'h5555_AAAA, 1, 4, -1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    check("ds_drop", frames_dropped, 1);
    bits(32'h5555_AAAA, 6, 31, -1, 1'b1);
    bits(32'h600D_CAFE, 0, 0, -1, 1'b1);
    check("ds_no_word", data_valid, 0);
    bits(32'h600D_CAFE, 1, 31, -1, 1'b1);
    bits(32'h0, 0, 0, -1, 1'b1);
    check("ds_realign_valid", data_valid, 1);
    check("ds_realign_data", data_out, 32'h600D_CAFE);
    check("ds_drop_final", frames_dropped, 1);

    // reset mid-operation with one word queued
    do_reset();
    bits(32'hFFFF_0000, 0, 31, 3, 1'b0);
    bits(32'h1357_9BDF, 0, 31, -1, 1'b0);
    bits(32'h2468_ACE0, 0, 16, -1, 1'b0);
    check("mr_queued", data_valid, 1);
    check("mr_head", data_out, 32'h1357_9BDF);
    check("mr_drop_pre", frames_dropped, 1);
    do_reset();
    check("mr_valid", data_valid, 0);
    check("mr_ovf", overflow, 0);
    check("mr_drop", frames_dropped, 0);
    bits(32'h8421_1248, 0, 31, -1, 1'b1);
    check("mr_no_stale", data_valid, 0);
    bits(32'h0, 0, 0, -1, 1'b1);
    check("mr_post_valid", data_valid, 1);
    check("mr_post_data", data_out, 32'h8421_1248);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_frame_collector.md
# serial_frame_collector

Downstream consumer of the 5-bit frame counter (`count`, `reached`). Samples one serial bit per clock in lockstep with the counter and assembles 32-bit frames. Pushes each valid frame into a small output FIFO drained by a valid/ready handshake. Detects dropped bits, counter desynchronisation and FIFO overflow.

## Interface
- `FIFO_DEPTH`, default 2: output FIFO entries; power of two, ≥2.
- `MSB_FIRST`, default 1: 1 = first-sampled bit lands in `data_out[31]`; 0 = first-sampled bit lands in `data_out[0]`.
- `clk` input 1: the single clock; all logic on its rising edge.
- `reset` input 1: synchronous, active-high.
- `serial_in` input 1: serial data bit for the current cycle.
- `bit_en` input 1: `serial_in` is valid this cycle.
- `count` input 5: bit index from the frame counter (0..31).
- `reached` input 1: frame counter wrap pulse; high in the cycle where `count` == 0 after a 31→0 wrap.
- `data_out` output 32: FIFO head word.
- `data_valid` output 1: FIFO non-empty.
- `data_ready` input 1: consumer accepts `data_out` this cycle.
- `overflow` output 1: sticky; a good frame was lost to a full FIFO.
- `frames_dropped` output 8: saturating count of discarded frames (any cause).

## Operation
- Reset values:
  - `data_out` = 0, `data_valid` = 0, `overflow` = 0, `frames_dropped` = 0.
  - FIFO is empty; shift register = 0; `frame_ok` = 0; state = ALIGN.
- Two states: ALIGN and COLLECT.
- ALIGN:
  - Ignores input until a cycle with `count` == 0, regardless of `reached`.
  - In that cycle: sample the bit as bit 0 of a new frame, set `frame_ok` = `bit_en`, go to COLLECT.
  - No push is ever made from ALIGN.
- COLLECT, every cycle:
  - Shift `serial_in` into the shift register: left-shift if `MSB_FIRST`, otherwise right-shift into bit 31.
  - Update `frame_ok` &= `bit_en`.
- Frame boundary (COLLECT, `reached` = 1, `count` = 0):
  - The shift register contents before this cycle's shift form the completed frame.
  - If `frame_ok`, request a push; otherwise drop the frame and increment `frames_dropped`.
  - This cycle's bit restarts the shift register as bit 0; `frame_ok` ← `bit_en`.
- Desync (COLLECT, `reached` ≠ (`count` == 0)):
  - Discard the partial frame, increment `frames_dropped`, go to ALIGN.
  - The same cycle does not re-align; the earliest re-align is the next `count` == 0.
- FIFO:
  - Pop on `data_valid && data_ready`.
  - Push when a push is requested and the FIFO is not full, or is full with a pop in the same cycle (push and pop both occur).
  - Push requested while full with no pop: frame dropped, `overflow` ← 1, `frames_dropped` incremented.
- `frames_dropped` saturates at 255 and increments by at most 1 per cycle.
- `overflow` clears only on `reset`.
- `data_out` holds the head word while `data_valid` = 1. When the FIFO is empty, `data_out` is don't-care but must not be X after reset.

## Timing
- Last bit of a frame sampled in cycle N (`count` = 31); `reached` is high in N+1; push at the end of N+1.
- With the FIFO previously empty, `data_valid` = 1 in cycle N+2: latency 2 cycles from the last bit.
- `data_valid` and `data_out` are registered; there is no combinational path from `data_ready` to any output.
- With `data_ready` held high, one word per 32 cycles; `data_valid` is high for exactly 1 cycle per frame.
- Reset mid-frame: all state returns to reset values on the next edge; partial frame and FIFO contents are discarded without counting.
- Counter and collector released from reset together: the first cycle has `count` = 0, `reached` = 0. ALIGN exits immediately; the first frame is bits from cycles 0..31.

## Test plan
- Basic frame:
  - Stimulus: reset at cycle 0 release; `bit_en` = 1, `data_ready` = 1, `MSB_FIRST` = 1; serial pattern 0xA5A5_0F0F over cycles 0..31.
  - Required: `data_valid` high only in cycle 33 with `data_out` = 0xA5A50F0F.
- Bit dropout:
  - Stimulus: `bit_en` = 0 at `count` = 7 of frame 1; frame 2 = 0x12345678 clean.
  - Required: no word for frame 1, `frames_dropped` = 1; frame 2 delivered as 0x12345678.
- Overflow:
  - Stimulus: `data_ready` = 0 for 4 frames 0x1, 0x2, 0x3, 0x4 (`FIFO_DEPTH` = 2); then `data_ready` = 1.
  - Required: `overflow` = 1, `frames_dropped` = 2; drains 0x1 then 0x2 on consecutive cycles.
- Push with simultaneous pop on a full FIFO:
  - Stimulus: FIFO full, `data_ready` pulsed high exactly in the push cycle.
  - Required: new frame accepted, `overflow` stays 0, FIFO remains full.
- Desync:
  - Stimulus: drive `reached` = 1 with `count` = 5.
  - Required: `frames_dropped` +1, no word for that frame; collector re-aligns at the next `count` = 0 and the following complete frame is delivered correctly.
- Reset mid-operation:
  - Stimulus: `reset` asserted at `count` = 17 with 1 word queued.
  - Required: next cycle `data_valid` = 0, `overflow` = 0, `frames_dropped` = 0; first frame after release delivered normally.
